// File: rtl/mod_exp_pkg.sv
// mod_exp_pkg: shared operand width and state encodings for the modular
// exponentiator (mod_exp) and its serial modular multiplier (mod_mul_serial).
package mod_exp_pkg;

  // Widest operand the ECC datapath uses (P-256 field elements).
  localparam int unsigned MAX_BITS = 256;

  // Square-and-multiply sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_WAIT_MUL = 3'd2,
    ST_SQR      = 3'd3,
    ST_WAIT_SQR = 3'd4,
    ST_DONE     = 3'd5
  } exp_state_e;

  // Serial multiplier states.
  typedef enum logic [1:0] {
    MS_IDLE  = 2'd0,
    MS_RUN   = 2'd1,
    MS_LATCH = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mod_exp_if.sv
// mod_exp_if: request/response bundle of the modular exponentiator.
//   i_start     start request (sampled only while the block is idle)
//   i_n         modulus, must be >= 2
//   i_base      base, must be < i_n
//   i_exp       unsigned exponent
//   o_result    i_base^i_exp mod i_n, stable from o_finished to next start
//   o_finished  one-cycle completion pulse
//   o_busy      operation in progress
// master = requester side, slave = mod_exp side.
interface mod_exp_if
  import mod_exp_pkg::*;
#(
  parameter int unsigned WIDTH = MAX_BITS
);

  logic             i_start;
  logic [WIDTH-1:0] i_n;
  logic [WIDTH-1:0] i_base;
  logic [WIDTH-1:0] i_exp;
  logic [WIDTH-1:0] o_result;
  logic             o_finished;
  logic             o_busy;

  modport master (
    output i_start, i_n, i_base, i_exp,
    input  o_result, o_finished, o_busy
  );

  modport slave (
    input  i_start, i_n, i_base, i_exp,
    output o_result, o_finished, o_busy
  );

endinterface

// File: rtl/mod_exp_mul_serial.sv
// mod_mul_serial: MSB-first shift-and-add modular multiplier,
// o_result = i_a * i_b mod i_n, for i_a < i_n and i_b < i_n.
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset
//   i_start     start pulse, operands captured on the same edge
//   i_n         modulus
//   i_a, i_b    multiplicand / multiplier
//   o_result    product, valid while o_finished is high and held afterwards
//   o_finished  one-cycle pulse, WIDTH+2 cycles after the i_start cycle
module mod_mul_serial
  import mod_exp_pkg::*;
#(
  parameter int unsigned WIDTH = MAX_BITS
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_n,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_finished
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  mul_state_e       r_state;
  mul_state_e       w_next;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_finished;

  logic             w_load;
  logic             w_step;
  logic             w_latch;
  logic [WIDTH:0]   w_dbl;
  logic [WIDTH:0]   w_dbl_red;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_acc_next;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= MS_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and datapath strobes.
  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_step  = 1'b0;
    w_latch = 1'b0;
    case (r_state)
      MS_IDLE: begin
        if (i_start) begin
          w_load = 1'b1;
          w_next = MS_RUN;
        end
      end
      MS_RUN: begin
        w_step = 1'b1;
        if (r_cnt == '0) begin
          w_next = MS_LATCH;
        end
      end
      MS_LATCH: begin
        w_latch = 1'b1;
        w_next  = MS_IDLE;
      end
      default: w_next = MS_IDLE;
    endcase
  end

  // One multiplier bit per cycle: acc = 2*acc mod n, then acc = acc + b mod n.
  // Both partial sums stay below 2n, so a single conditional subtract suffices.
  always_comb begin
    w_dbl      = {r_acc, 1'b0};
    w_dbl_red  = (w_dbl >= {1'b0, r_n}) ? (w_dbl - {1'b0, r_n}) : w_dbl;
    w_sum      = w_dbl_red + (r_a[WIDTH-1] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    w_acc_next = (w_sum >= {1'b0, r_n}) ? WIDTH'(w_sum - {1'b0, r_n}) : WIDTH'(w_sum);
  end

  // Operand, accumulator and result registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_n        <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_finished <= 1'b0;
    end else begin
      if (w_load) begin
        r_n   <= i_n;
        r_a   <= i_a;
        r_b   <= i_b;
        r_acc <= '0;
        r_cnt <= CNT_W'(WIDTH - 1);
      end
      if (w_step) begin
        r_acc <= w_acc_next;
        r_a   <= r_a << 1;
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_latch) begin
        r_result <= r_acc;
      end
      r_finished <= w_latch;
    end
  end

  assign o_result   = r_result;
  assign o_finished = r_finished;

endmodule

// File: rtl/mod_exp.sv
// mod_exp: o_result = i_base^i_exp mod i_n by right-to-left binary
// square-and-multiply over a single serial modular multiplier.
//   i_clk  clock, rising edge
//   i_rst  synchronous active-high reset; aborts any operation in flight
//   bus    mod_exp_if.slave: i_start/i_n/i_base/i_exp in,
//          o_result/o_finished/o_busy out
module mod_exp
  import mod_exp_pkg::*;
#(
  parameter int unsigned WIDTH = MAX_BITS
) (
  input  logic     i_clk,
  input  logic     i_rst,
  mod_exp_if.slave bus
);

  exp_state_e       r_state;
  exp_state_e       w_next;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_e;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_result;
  logic             r_finished;
  logic             r_busy;

  logic             w_capture;
  logic             w_take_mul;
  logic             w_take_sqr;
  logic             w_mul_start;
  logic [WIDTH-1:0] w_mul_a;
  logic [WIDTH-1:0] w_mul_result;
  logic             w_mul_finished;
  logic [WIDTH-1:0] w_r_next;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, multiplier issue and datapath strobes.
  always_comb begin
    w_next      = r_state;
    w_capture   = 1'b0;
    w_take_mul  = 1'b0;
    w_take_sqr  = 1'b0;
    w_mul_start = 1'b0;
    w_mul_a     = r_r;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_start) begin
          w_capture = 1'b1;
          w_next    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (r_e == '0) begin
          w_next = ST_DONE;
        end else if (r_e[0]) begin
          w_mul_start = 1'b1;
          w_mul_a     = r_r;
          w_next      = ST_WAIT_MUL;
        end else begin
          w_next = ST_SQR;
        end
      end
      ST_WAIT_MUL: begin
        if (w_mul_finished) begin
          w_take_mul = 1'b1;
          // No squaring once the top set exponent bit has been consumed.
          w_next = ((r_e >> 1) == '0) ? ST_DONE : ST_SQR;
        end
      end
      ST_SQR: begin
        w_mul_start = 1'b1;
        w_mul_a     = r_b;
        w_next      = ST_WAIT_SQR;
      end
      ST_WAIT_SQR: begin
        if (w_mul_finished) begin
          w_take_sqr = 1'b1;
          w_next     = ST_CHECK;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Value r_r takes on this edge; lets o_result pick up a product that
  // lands on the same edge as the move into DONE.
  assign w_r_next = w_take_mul ? w_mul_result : r_r;

  // Working registers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_n        <= '0;
      r_b        <= '0;
      r_e        <= '0;
      r_r        <= '0;
      r_result   <= '0;
      r_finished <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      if (w_capture) begin
        r_n <= bus.i_n;
        r_b <= bus.i_base;
        r_e <= bus.i_exp;
        r_r <= WIDTH'(1);
      end
      if (w_take_mul) begin
        r_r <= w_mul_result;
      end
      if (w_take_sqr) begin
        r_b <= w_mul_result;
        r_e <= r_e >> 1;
      end
      if (w_next == ST_DONE) begin
        r_result <= w_r_next;
      end
      r_finished <= (w_next == ST_DONE);
      r_busy     <= (w_next != ST_IDLE);
    end
  end

  // Operand a is muxed between r_r (multiply) and r_b (square); b is always r_b.
  mod_mul_serial #(
    .WIDTH (WIDTH)
  ) u_mul (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (w_mul_start),
    .i_n        (r_n),
    .i_a        (w_mul_a),
    .i_b        (r_b),
    .o_result   (w_mul_result),
    .o_finished (w_mul_finished)
  );

  assign bus.o_result   = r_result;
  assign bus.o_finished = r_finished;
  assign bus.o_busy     = r_busy;

endmodule

// File: tb/tb_mod_exp.sv
// tb_mod_exp: scoreboard bench for mod_exp. Expected results are pushed when
// a start is driven and popped when o_finished is observed.
module tb_mod_exp;
  import mod_exp_pkg::*;

  localparam int unsigned W            = 64;
  localparam logic [W-1:0] P64         = 64'hFFFF_FFFF_FFFF_FFC5;
  localparam int          SHORT_BUDGET = 2000;
  localparam int          LONG_BUDGET  = 20000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mod_exp_if #(.WIDTH(W)) bus ();

  mod_exp #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int fin_cnt  = 0;
  int mul_cnt  = 0;
  logic [W-1:0] sb_q[$];

  // Count completion pulses and multiplier issues seen at each edge.
  always @(posedge clk) begin
    if (bus.o_finished === 1'b1) fin_cnt = fin_cnt + 1;
    if (dut.w_mul_start === 1'b1) mul_cnt = mul_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  function automatic logic [W-1:0] ref_mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [W-1:0] n);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    p = p % {{W{1'b0}}, n};
    return p[W-1:0];
  endfunction

  function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                              input logic [W-1:0] n);
    logic [W-1:0] r, bb, ee;
    r  = W'(1);
    bb = b;
    ee = e;
    for (int i = 0; i < W; i++) begin
      if (ee[0]) r = ref_mulmod(r, bb, n);
      bb = ref_mulmod(bb, bb, n);
      ee = ee >> 1;
    end
    return r;
  endfunction

  function automatic int ref_mul_count(input logic [W-1:0] e);
    int bl;
    bl = 0;
    for (int i = 0; i < W; i++) if (e[i]) bl = i + 1;
    return (e == '0) ? 0 : ($countones(e) + bl - 1);
  endfunction

  // Drive a start for one cycle; returns at accepting edge + 1.
  task automatic start_op(input logic [W-1:0] n, input logic [W-1:0] b, input logic [W-1:0] e);
    bus.i_n     = n;
    bus.i_base  = b;
    bus.i_exp   = e;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
  endtask

  // Advance until o_finished is seen or the budget runs out.
  task automatic wait_fin(input int budget, output int cyc);
    cyc = 0;
    while (bus.o_finished !== 1'b1 && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.o_result !== '0 || bus.o_finished !== 1'b0 || bus.o_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs result=%0h finished=%b busy=%b required 0/0/0",
               bus.o_result, bus.o_finished, bus.o_busy);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int m0, f0, cyc;
    logic [W-1:0] exp_v;
    m0 = mul_cnt; f0 = fin_cnt;
    sb_q.push_back(W'(10));
    start_op(W'(23), W'(5), W'(3));
    wait_fin(SHORT_BUDGET, cyc);
    checks++;
    if (bus.o_finished !== 1'b1) begin
      failures++; $display("FAIL basic_done finished=%b required=1", bus.o_finished);
    end
    exp_v = sb_q.pop_front();
    checks++;
    if (bus.o_result !== exp_v) begin
      failures++; $display("FAIL basic_result got=%0h required=%0h", bus.o_result, exp_v);
    end
    checks++;
    if (mul_cnt - m0 !== 3) begin
      failures++; $display("FAIL basic_mul_count got=%0d required=3", mul_cnt - m0);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.o_finished !== 1'b0 || bus.o_busy !== 1'b0 || fin_cnt - f0 !== 1) begin
      failures++;
      $display("FAIL basic_pulse finished=%b busy=%b pulses=%0d required 0/0/1",
               bus.o_finished, bus.o_busy, fin_cnt - f0);
    end
  endtask

  task automatic test_exp_zero();
    int m0, cyc;
    logic [W-1:0] exp_v;
    m0 = mul_cnt;
    sb_q.push_back(W'(1));
    start_op(W'(23), W'(5), W'(0));
    checks++;
    if (bus.o_busy !== 1'b1 || bus.o_finished !== 1'b0) begin
      failures++; $display("FAIL zero_first_cycle busy=%b finished=%b required 1/0",
                           bus.o_busy, bus.o_finished);
    end
    wait_fin(SHORT_BUDGET, cyc);
    checks++;
    if (bus.o_finished !== 1'b1 || cyc !== 1) begin
      failures++; $display("FAIL zero_latency edges_after_accept=%0d required=1", cyc);
    end
    exp_v = sb_q.pop_front();
    checks++;
    if (bus.o_result !== exp_v) begin
      failures++; $display("FAIL zero_result got=%0h required=%0h", bus.o_result, exp_v);
    end
    checks++;
    if (mul_cnt - m0 !== 0) begin
      failures++; $display("FAIL zero_mul_count got=%0d required=0", mul_cnt - m0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_exp_one();
    int m0, cyc;
    logic [W-1:0] exp_v;
    m0 = mul_cnt;
    sb_q.push_back(W'(17));
    start_op(W'(23), W'(17), W'(1));
    wait_fin(SHORT_BUDGET, cyc);
    checks++;
    if (bus.o_finished !== 1'b1) begin
      failures++; $display("FAIL one_done finished=%b required=1", bus.o_finished);
    end
    exp_v = sb_q.pop_front();
    checks++;
    if (bus.o_result !== exp_v) begin
      failures++; $display("FAIL one_result got=%0h required=%0h", bus.o_result, exp_v);
    end
    checks++;
    if (mul_cnt - m0 !== 1) begin
      failures++; $display("FAIL one_mul_count got=%0d required=1", mul_cnt - m0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_restart_ignored();
    int m0, f0, cyc;
    logic [W-1:0] exp_v;
    m0 = mul_cnt; f0 = fin_cnt;
    sb_q.push_back(W'(10));
    start_op(W'(23), W'(5), W'(3));
    repeat (20) @(posedge clk);
    #1;
    start_op(W'(29), W'(3), W'(7));
    wait_fin(SHORT_BUDGET, cyc);
    checks++;
    if (bus.o_finished !== 1'b1) begin
      failures++; $display("FAIL restart_done finished=%b required=1", bus.o_finished);
    end
    exp_v = sb_q.pop_front();
    checks++;
    if (bus.o_result !== exp_v) begin
      failures++; $display("FAIL restart_result got=%0h required=%0h", bus.o_result, exp_v);
    end
    // Start held during the DONE cycle must not be taken.
    start_op(W'(29), W'(3), W'(7));
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_finished !== 1'b0) begin
      failures++; $display("FAIL restart_done_cycle_start busy=%b finished=%b required 0/0",
                           bus.o_busy, bus.o_finished);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (fin_cnt - f0 !== 1 || mul_cnt - m0 !== 3 || bus.o_result !== W'(10) || bus.o_busy !== 1'b0) begin
      failures++;
      $display("FAIL restart_after pulses=%0d muls=%0d result=%0h busy=%b required 1/3/a/0",
               fin_cnt - f0, mul_cnt - m0, bus.o_result, bus.o_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] n, b, e, exp_v;
    int m0, cyc, want_muls;
    for (int k = 0; k < 4; k++) begin
      n = {$urandom, $urandom};
      if (n < W'(2)) n = W'(2);
      b = {$urandom, $urandom} % n;
      e = W'($urandom_range(0, 65535));
      want_muls = ref_mul_count(e);
      m0 = mul_cnt;
      sb_q.push_back(ref_modexp(b, e, n));
      start_op(n, b, e);
      checks++;
      if (bus.o_busy !== 1'b1) begin
        failures++; $display("FAIL b2b_accept_%0d busy=%b required=1", k, bus.o_busy);
      end
      wait_fin(LONG_BUDGET, cyc);
      checks++;
      if (bus.o_finished !== 1'b1) begin
        failures++; $display("FAIL b2b_done_%0d finished=%b required=1", k, bus.o_finished);
      end
      exp_v = sb_q.pop_front();
      checks++;
      if (bus.o_result !== exp_v || mul_cnt - m0 !== want_muls) begin
        failures++;
        $display("FAIL b2b_result_%0d got=%0h muls=%0d required=%0h muls=%0d",
                 k, bus.o_result, mul_cnt - m0, exp_v, want_muls);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fermat();
    logic [W-1:0] e, exp_v, x;
    int m0, cyc, want_muls;
    for (int k = 0; k < 2; k++) begin
      e = (k == 0) ? (P64 - W'(1)) : (P64 - W'(2));
      want_muls = ref_mul_count(e);
      m0 = mul_cnt;
      sb_q.push_back((k == 0) ? W'(1) : ref_modexp(W'(7), e, P64));
      start_op(P64, W'(7), e);
      wait_fin(LONG_BUDGET, cyc);
      checks++;
      if (bus.o_finished !== 1'b1) begin
        failures++; $display("FAIL fermat_done_%0d finished=%b required=1", k, bus.o_finished);
      end
      exp_v = sb_q.pop_front();
      x = bus.o_result;
      checks++;
      if (x !== exp_v || mul_cnt - m0 !== want_muls) begin
        failures++;
        $display("FAIL fermat_result_%0d got=%0h muls=%0d required=%0h muls=%0d",
                 k, x, mul_cnt - m0, exp_v, want_muls);
      end
      if (k == 1) begin
        checks++;
        if (ref_mulmod(W'(7), x, P64) !== W'(1)) begin
          failures++; $display("FAIL fermat_inverse 7*x mod p=%0h required=1",
                               ref_mulmod(W'(7), x, P64));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midop();
    int f0, cyc;
    logic [W-1:0] exp_v;
    start_op(P64, W'(7), P64 - W'(2));
    repeat (200) @(posedge clk);
    #1;
    cyc = 0;
    while (dut.r_state !== ST_WAIT_SQR && cyc < SHORT_BUDGET) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (dut.r_state !== ST_WAIT_SQR) begin
      failures++; $display("FAIL midreset_reach state=%0d required=%0d",
                           int'(dut.r_state), int'(ST_WAIT_SQR));
    end
    f0 = fin_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (dut.r_state !== ST_IDLE || bus.o_result !== '0 || bus.o_busy !== 1'b0 ||
        bus.o_finished !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state state=%0d result=%0h busy=%b finished=%b required idle/0/0/0",
               int'(dut.r_state), bus.o_result, bus.o_busy, bus.o_finished);
    end
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (fin_cnt !== f0 || bus.o_busy !== 1'b0) begin
      failures++; $display("FAIL midreset_no_finish pulses=%0d busy=%b required 0/0",
                           fin_cnt - f0, bus.o_busy);
    end
    sb_q.push_back(W'(10));
    start_op(W'(23), W'(5), W'(3));
    wait_fin(SHORT_BUDGET, cyc);
    checks++;
    if (bus.o_finished !== 1'b1) begin
      failures++; $display("FAIL midreset_fresh_done finished=%b required=1", bus.o_finished);
    end
    exp_v = sb_q.pop_front();
    checks++;
    if (bus.o_result !== exp_v) begin
      failures++; $display("FAIL midreset_fresh_result got=%0h required=%0h", bus.o_result, exp_v);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst         = 1'b1;
    bus.i_start = 1'b0;
    bus.i_n     = '0;
    bus.i_base  = '0;
    bus.i_exp   = '0;
    test_reset();
    test_basic();
    test_exp_zero();
    test_exp_one();
    test_restart_ignored();
    test_back_to_back();
    test_fermat();
    test_reset_midop();
    checks++;
    if (sb_q.size() !== 0) begin
      failures++; $display("FAIL scoreboard_leftover entries=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
